// File: rtl/doorlock_core.sv
// doorlock_core: PIN lock controller with entry buffer, programmable password, failed-attempt
// lockout and auto-relock. Define DOORLOCK_MASTER_EN to add the master code; "prog" is the program strobe.
module doorlock_core #(
  parameter int DIGIT_W = 4,
  parameter int MAX_DIGITS = 8,
  parameter int MIN_DIGITS = 4,
  parameter logic [MAX_DIGITS*DIGIT_W-1:0] DEFAULT_PW = 32'h2718,
  parameter int DEFAULT_LEN = 4,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int UNLOCK_CYCLES = 500
`ifdef DOORLOCK_MASTER_EN
  ,
  parameter logic [MAX_DIGITS*DIGIT_W-1:0] MASTER_PW = 32'h1234,
  parameter int MASTER_LEN = 4
`endif
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 digit_valid,
  input  logic [DIGIT_W-1:0]                   digit,
  input  logic                                 confirm,
  input  logic                                 prog,
  input  logic                                 cancel,
  output logic                                 locked,
  output logic                                 lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0]       fail_cnt,
  output logic [$clog2(MAX_DIGITS+1)-1:0]      entry_len,
  output logic                                 ok_pulse,
  output logic                                 fail_pulse
);

  localparam int BW   = MAX_DIGITS * DIGIT_W;
  localparam int LW   = $clog2(MAX_DIGITS + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_PROGRAM, S_LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic [BW-1:0] pw_q, pw_d;
  logic [LW-1:0] pw_len_q, pw_len_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          locked_q, locked_d;
  logic          lockout_q, lockout_d;
  logic          ok_q, ok_d;
  logic          failp_q, failp_d;

  logic          digit_ok;
  logic          user_match;
  logic          master_hit;
  logic          append;
  logic          clear;
  logic [FW-1:0] fail_next;

  assign digit_ok   = digit_valid && (32'(digit) <= 32'd9);
  // The buffer is zero above entry_len digits, so a full-width compare plus length check suffices.
  assign user_match = !ovf_q && (len_q == pw_len_q) && (buf_q == pw_q);
  assign fail_next  = (fail_q == FW'(MAX_FAILS)) ? fail_q : fail_q + FW'(1);

`ifdef DOORLOCK_MASTER_EN
  logic master_match;
  assign master_match = !ovf_q && (len_q == LW'(MASTER_LEN)) && (buf_q == MASTER_PW);
  assign master_hit   = master_match;
`else
  assign master_hit   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    pw_d      = pw_q;
    pw_len_d  = pw_len_q;
    fail_d    = fail_q;
    timer_d   = timer_q;
    locked_d  = locked_q;
    lockout_d = lockout_q;
    ok_d      = 1'b0;
    failp_d   = 1'b0;
    append    = 1'b0;
    clear     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (digit_ok) begin
          state_d = S_ENTRY;
          append  = 1'b1;
        end
      end
      S_ENTRY: begin
        if (cancel) begin
          clear   = 1'b1;
          state_d = S_IDLE;
        end else if (confirm) begin
          state_d = S_CHECK;
        end else if (digit_ok) begin
          append = 1'b1;
        end
      end
      S_CHECK: begin
        clear = 1'b1;
        if (user_match || master_hit) begin
          state_d  = S_UNLOCKED;
          locked_d = 1'b0;
          ok_d     = 1'b1;
          fail_d   = '0;
          timer_d  = '0;
        end else begin
          failp_d = 1'b1;
          fail_d  = fail_next;
          if (fail_next == FW'(MAX_FAILS)) begin
            state_d   = S_LOCKOUT;
            lockout_d = 1'b1;
            timer_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_UNLOCKED: begin
        if (confirm || (timer_q == TW'(UNLOCK_CYCLES - 1))) begin
          state_d  = S_IDLE;
          locked_d = 1'b1;
        end else if (prog) begin
          state_d = S_PROGRAM;
          clear   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_PROGRAM: begin
        if (cancel) begin
          clear   = 1'b1;
          state_d = S_UNLOCKED;
          timer_d = '0;
        end else if (confirm) begin
          clear    = 1'b1;
          state_d  = S_IDLE;
          locked_d = 1'b1;
          if (!ovf_q && (len_q >= LW'(MIN_DIGITS))) begin
            pw_d     = buf_q;
            pw_len_d = len_q;
            ok_d     = 1'b1;
          end else begin
            failp_d = 1'b1;
          end
        end else if (digit_ok) begin
          append = 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
          state_d   = S_IDLE;
          lockout_d = 1'b0;
          fail_d    = '0;
          clear     = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
`ifdef DOORLOCK_MASTER_EN
          if (cancel) begin
            clear = 1'b1;
          end else if (confirm) begin
            clear = 1'b1;
            if (master_match) begin
              state_d   = S_UNLOCKED;
              lockout_d = 1'b0;
              locked_d  = 1'b0;
              fail_d    = '0;
              ok_d      = 1'b1;
              timer_d   = '0;
            end
          end else if (digit_ok) begin
            append = 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Digits past MAX_DIGITS are dropped but poison the pending submission.
    if (clear) begin
      buf_d = '0;
      len_d = '0;
      ovf_d = 1'b0;
    end else if (append) begin
      if (len_q == LW'(MAX_DIGITS)) begin
        ovf_d = 1'b1;
      end else begin
        buf_d = (buf_q << DIGIT_W) | BW'(digit);
        len_d = len_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      buf_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      pw_q      <= DEFAULT_PW;
      pw_len_q  <= LW'(DEFAULT_LEN);
      fail_q    <= '0;
      timer_q   <= '0;
      locked_q  <= 1'b1;
      lockout_q <= 1'b0;
      ok_q      <= 1'b0;
      failp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      pw_q      <= pw_d;
      pw_len_q  <= pw_len_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      locked_q  <= locked_d;
      lockout_q <= lockout_d;
      ok_q      <= ok_d;
      failp_q   <= failp_d;
    end
  end

  assign locked     = locked_q;
  assign lockout    = lockout_q;
  assign fail_cnt   = fail_q;
  assign entry_len  = len_q;
  assign ok_pulse   = ok_q;
  assign fail_pulse = failp_q;

endmodule

// File: tb/tb_doorlock_core.sv
// tb_doorlock_core: directed vector table plus hand-written multi-cycle sequences for doorlock_core
// (UNLOCK_CYCLES=16, LOCKOUT_CYCLES=20, other parameters at their defaults).
module tb_doorlock_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       confirm = 1'b0;
  logic       prog = 1'b0;
  logic       cancel = 1'b0;
  logic       locked, lockout, ok_pulse, fail_pulse;
  logic [1:0] fail_cnt;
  logic [3:0] entry_len;
  logic [9:0] outs;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       cf;
    logic       pg;
    logic       cn;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  assign outs = {locked, lockout, fail_cnt, entry_len, ok_pulse, fail_pulse};

  doorlock_core #(.UNLOCK_CYCLES(16), .LOCKOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .confirm(confirm), .prog(prog), .cancel(cancel),
    .locked(locked), .lockout(lockout), .fail_cnt(fail_cnt),
    .entry_len(entry_len), .ok_pulse(ok_pulse), .fail_pulse(fail_pulse)
  );

  function automatic vec_t V(input int v, input int d, input int cf, input int pg, input int cn,
                             input int lk, input int lo, input int fc, input int len,
                             input int ok, input int fp);
    vec_t r;
    r.v   = v[0];
    r.d   = d[3:0];
    r.cf  = cf[0];
    r.pg  = pg[0];
    r.cn  = cn[0];
    r.exp = {lk[0], lo[0], fc[1:0], len[3:0], ok[0], fp[0]};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t vec);
    digit_valid = vec.v;
    digit       = vec.d;
    confirm     = vec.cf;
    prog        = vec.pg;
    cancel      = vec.cn;
    tick();
    digit_valid = 1'b0;
    confirm     = 1'b0;
    prog        = 1'b0;
    cancel      = 1'b0;
  endtask

  task automatic press(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic enter_pin(input logic [63:0] pin, input int n);
    for (int i = n - 1; i >= 0; i--) press(pin[4*i +: 4]);
  endtask

  task automatic strobe_confirm();
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
  endtask

  task automatic submit();
    strobe_confirm();
    tick();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    logic saw_unlock;

    // v d cf pg cn | locked lockout fail_cnt entry_len ok fail
    tbl.push_back(V(0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 12, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 2, 0, 0, 0,  1, 0, 0, 1, 0, 0));
    tbl.push_back(V(1, 7, 0, 0, 0,  1, 0, 0, 2, 0, 0));
    tbl.push_back(V(1, 15, 0, 0, 0, 1, 0, 0, 2, 0, 0));
    tbl.push_back(V(1, 1, 0, 0, 0,  1, 0, 0, 3, 0, 0));
    tbl.push_back(V(1, 8, 0, 0, 0,  1, 0, 0, 4, 0, 0));
    tbl.push_back(V(0, 0, 1, 0, 0,  1, 0, 0, 4, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
    tbl.push_back(V(1, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0));
    tbl.push_back(V(1, 2, 0, 0, 0,  1, 0, 0, 1, 0, 0));
    tbl.push_back(V(1, 7, 0, 0, 0,  1, 0, 0, 2, 0, 0));
    tbl.push_back(V(1, 1, 0, 0, 0,  1, 0, 0, 3, 0, 0));
    tbl.push_back(V(1, 9, 0, 0, 0,  1, 0, 0, 4, 0, 0));
    tbl.push_back(V(0, 0, 1, 0, 0,  1, 0, 0, 4, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1));
    tbl.push_back(V(1, 5, 0, 0, 0,  1, 0, 1, 1, 0, 0));
    tbl.push_back(V(1, 5, 0, 0, 1,  1, 0, 1, 0, 0, 0));
    tbl.push_back(V(1, 4, 0, 0, 0,  1, 0, 1, 1, 0, 0));
    tbl.push_back(V(1, 6, 1, 0, 0,  1, 0, 1, 1, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0,  1, 0, 2, 0, 0, 1));
    tbl.push_back(V(1, 2, 0, 0, 0,  1, 0, 2, 1, 0, 0));
    tbl.push_back(V(1, 7, 0, 0, 0,  1, 0, 2, 2, 0, 0));
    tbl.push_back(V(1, 1, 0, 0, 0,  1, 0, 2, 3, 0, 0));
    tbl.push_back(V(1, 8, 0, 0, 0,  1, 0, 2, 4, 0, 0));
    tbl.push_back(V(0, 0, 1, 0, 0,  1, 0, 2, 4, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0));
    tbl.push_back(V(0, 0, 1, 1, 0,  1, 0, 0, 0, 0, 0));

    tick();
    tick();
    checkOutput("reset outputs", 32'(outs), 32'h200);
    rst = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("vector %0d", i), 32'(outs), 32'(tbl[i].exp));
    end

    // Unlock then auto-relock after 16 cycles.
    enter_pin(64'h2718, 4);
    submit();
    checkOutput("unlock ok_pulse", 32'(ok_pulse), 32'd1);
    checkOutput("unlock locked", 32'(locked), 32'd0);
    k = 0;
    while (locked !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    checkOutput("auto-relock cycles", 32'(k), 32'd16);

    // Three failures trigger a 20-cycle lockout that ignores a correct PIN.
    for (int n = 1; n <= 3; n++) begin
      enter_pin(64'h2719, 4);
      submit();
      checkOutput($sformatf("wrong pin %0d fail_pulse", n), 32'(fail_pulse), 32'd1);
      checkOutput($sformatf("wrong pin %0d fail_cnt", n), 32'(fail_cnt), 32'(n));
    end
    checkOutput("lockout entered", 32'(lockout), 32'd1);
    k = 0;
    saw_unlock = 1'b0;
    while (lockout === 1'b1 && k < 40) begin
      case (k)
        0: begin digit_valid = 1'b1; digit = 4'd2; end
        1: begin digit_valid = 1'b1; digit = 4'd7; end
        2: begin digit_valid = 1'b1; digit = 4'd1; end
        3: begin digit_valid = 1'b1; digit = 4'd8; end
        4: confirm = 1'b1;
        default: ;
      endcase
      tick();
      digit_valid = 1'b0;
      confirm = 1'b0;
      if (locked !== 1'b1) saw_unlock = 1'b1;
      k++;
    end
    checkOutput("lockout duration", 32'(k), 32'd20);
    checkOutput("lockout kept locked", 32'(saw_unlock), 32'd0);
    checkOutput("fail_cnt after lockout", 32'(fail_cnt), 32'd0);

    // Programming a too-short PIN is rejected and keeps the old password.
    enter_pin(64'h2718, 4);
    submit();
    checkOutput("unlock before short program", 32'(locked), 32'd0);
    prog = 1'b1;
    tick();
    prog = 1'b0;
    checkOutput("program mode outputs", 32'(outs), 32'h000);
    enter_pin(64'h123, 3);
    strobe_confirm();
    checkOutput("short program result", 32'(outs), 32'h201);
    enter_pin(64'h2718, 4);
    submit();
    checkOutput("old pin still unlocks", 32'(outs), 32'h002);

    // Program 55555, then old PIN fails and the new one unlocks.
    prog = 1'b1;
    tick();
    prog = 1'b0;
    enter_pin(64'h55555, 5);
    checkOutput("program entry_len", 32'(entry_len), 32'd5);
    strobe_confirm();
    checkOutput("program accepted", 32'(outs), 32'h202);
    tick();
    checkOutput("ok_pulse single cycle", 32'(ok_pulse), 32'd0);
    enter_pin(64'h2718, 4);
    submit();
    checkOutput("old pin rejected", 32'(outs), 32'h241);
    enter_pin(64'h55555, 5);
    submit();
    checkOutput("new pin unlocks", 32'(outs), 32'h002);
    strobe_confirm();
    checkOutput("manual relock", 32'(locked), 32'd1);

    // Overflow saturates entry_len and forces failure; cancel counts nothing.
    enter_pin(64'h123456789, 9);
    checkOutput("overflow entry_len", 32'(entry_len), 32'd8);
    submit();
    checkOutput("overflow rejected", 32'(outs), 32'h241);
    press(4'd1);
    press(4'd2);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checkOutput("cancel outputs", 32'(outs), 32'h240);
    tick();
    checkOutput("cancel no fail_pulse", 32'(fail_pulse), 32'd0);

    // Asynchronous reset mid-entry restores the default password.
    enter_pin(64'h55, 2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset outputs", 32'(outs), 32'h200);
    tick();
    rst = 1'b0;
    enter_pin(64'h2718, 4);
    submit();
    checkOutput("default pin after reset", 32'(outs), 32'h002);
    strobe_confirm();

`ifdef DOORLOCK_MASTER_EN
    for (int n = 1; n <= 3; n++) begin
      enter_pin(64'h9999, 4);
      submit();
    end
    checkOutput("master: lockout forced", 32'(lockout), 32'd1);
    enter_pin(64'h1234, 4);
    strobe_confirm();
    checkOutput("master: lockout aborted", 32'(outs), 32'h002);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
